// File: rtl/keypad_pkg.sv
// Shared constants, state encoding and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam logic [15:0] KEY_NONE = 16'hFFFF;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_SCAN  = 2'd1,
    S_FRAME = 2'd2
  } state_e;

  // One-cold row drive for the given row index.
  function automatic logic [3:0] row_drive(logic [1:0] idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  function automatic logic [4:0] popcount16(logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and encoder-side signal bundle for the scan controller.
interface keypad_scan_ctrl_if;
  logic        scan_en;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] key_num;
  logic        frame_tick;
  logic        multi_key;

  // Environment side: enables scanning and presents the column pins.
  modport master (
    output scan_en,
    output col_n,
    input  row_n,
    input  key_num,
    input  frame_tick,
    input  multi_key
  );

  // Scanner side.
  modport slave (
    input  scan_en,
    input  col_n,
    output row_n,
    output key_num,
    output frame_tick,
    output multi_key
  );
endinterface

// File: rtl/kp_sync2.sv
// Two-flop synchronizer for the asynchronous keypad column inputs.
module kp_sync2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Columns are pulled up, so idle is all ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with whole-frame debounce and multi-key flag.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               clk_100M,
  input  logic               rst_n,
  keypad_scan_ctrl_if.slave  bus
);

  localparam int unsigned StW = (DEBOUNCE_FRAMES < 1) ? 1 : $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SCAN_DIV - 1);
  localparam logic [StW-1:0]   StMax   = StW'(DEBOUNCE_FRAMES);

  state_e           state_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      raw_q;
  logic [15:0]      prev_raw_q;
  logic [StW-1:0]   stable_q;
  logic [3:0]       row_n_q;
  logic [15:0]      key_num_q;
  logic             frame_tick_q;
  logic             multi_key_q;

  logic [3:0]       col_s;
  logic [15:0]      raw_frame;
  logic [StW-1:0]   stable_d;
  logic             commit;

  kp_sync2 u_sync (
    .clk_i  (clk_100M),
    .rst_ni (rst_n),
    .d_i    (bus.col_n),
    .q_o    (col_s)
  );

  // Frame as it will look once the current slot's sample lands; the debounce
  // decision is made on the edge entering S_FRAME so key_num and frame_tick
  // are visible together during that cycle.
  always_comb begin
    raw_frame = raw_q;
    raw_frame[{idx_q, 2'b00} +: 4] = col_s;
    if (raw_frame != prev_raw_q) begin
      stable_d = StW'(1);
    end else if (stable_q >= StMax) begin
      stable_d = StMax;
    end else begin
      stable_d = stable_q + StW'(1);
    end
    commit = (stable_d >= StMax);
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      raw_q        <= KEY_NONE;
      prev_raw_q   <= KEY_NONE;
      stable_q     <= StMax;
      row_n_q      <= 4'hF;
      key_num_q    <= KEY_NONE;
      frame_tick_q <= 1'b0;
      multi_key_q  <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      multi_key_q  <= (popcount16(~key_num_q) >= 5'd2);
      if (!bus.scan_en) begin
        // Park: partial frame is dropped, debounce history is kept.
        state_q <= S_OFF;
        row_n_q <= 4'hF;
        cnt_q   <= '0;
        idx_q   <= 2'd0;
      end else begin
        unique case (state_q)
          S_OFF: begin
            state_q <= S_SCAN;
            row_n_q <= row_drive(2'd0);
            cnt_q   <= '0;
            idx_q   <= 2'd0;
          end
          S_SCAN: begin
            if (cnt_q == CntLast) begin
              cnt_q <= '0;
              raw_q <= raw_frame;
              if (idx_q == 2'd3) begin
                state_q      <= S_FRAME;
                row_n_q      <= 4'hF;
                idx_q        <= 2'd0;
                frame_tick_q <= 1'b1;
                prev_raw_q   <= raw_frame;
                stable_q     <= stable_d;
                if (commit) begin
                  key_num_q <= raw_frame;
                end
              end else begin
                idx_q   <= idx_q + 2'd1;
                row_n_q <= row_drive(idx_q + 2'd1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_FRAME: begin
            state_q <= S_SCAN;
            row_n_q <= row_drive(2'd0);
            cnt_q   <= '0;
            idx_q   <= 2'd0;
          end
          default: begin
            state_q <= S_OFF;
            row_n_q <= 4'hF;
          end
        endcase
      end
    end
  end

  assign bus.row_n      = row_n_q;
  assign bus.key_num    = key_num_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.multi_key  = multi_key_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench: two scanners (debounce 4 and 1) driven by one keypad model.
module tb_keypad_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        scan_en;
  logic [15:0] press;

  int checks;
  int failures;
  bit mon_en;
  bit mon_left;

  keypad_scan_ctrl_if bus4 ();
  keypad_scan_ctrl_if bus1 ();

  keypad_scan_ctrl #(
    .SCAN_DIV        (8),
    .DEBOUNCE_FRAMES (4),
    .CNT_W           (16)
  ) dut (
    .clk_100M (clk),
    .rst_n    (rst_n),
    .bus      (bus4.slave)
  );

  keypad_scan_ctrl #(
    .SCAN_DIV        (8),
    .DEBOUNCE_FRAMES (1),
    .CNT_W           (16)
  ) dut1 (
    .clk_100M (clk),
    .rst_n    (rst_n),
    .bus      (bus1.slave)
  );

  function automatic logic [3:0] cols(logic [3:0] rn, logic [15:0] p);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (!rn[r] && p[r*4+k]) c[k] = 1'b0;
      end
    end
    return c;
  endfunction

  assign bus4.scan_en = scan_en;
  assign bus1.scan_en = scan_en;
  assign bus4.col_n   = cols(bus4.row_n, press);
  assign bus1.col_n   = cols(bus1.row_n, press);

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && bus4.key_num !== 16'hFFFF) mon_left = 1'b1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Wait for n frame ticks of the DEBOUNCE_FRAMES=4 scanner; ends on the tick cycle.
  task automatic wait_ticks(input int n);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < 40 * n + 40) begin
      @(negedge clk);
      cyc++;
      if (bus4.frame_tick) seen++;
    end
    checks++;
    if (seen != n) begin
      failures++;
      $display("FAIL wait_ticks: got %0d ticks required %0d", seen, n);
    end
  endtask

  task automatic test_reset();
    int ticks;
    int bad_rows;
    rst_n = 1'b0;
    #12;
    chk16("reset_row_n", {12'h000, bus4.row_n}, 16'h000F);
    chk16("reset_key_num", bus4.key_num, 16'hFFFF);
    chk1("reset_frame_tick", bus4.frame_tick, 1'b0);
    chk1("reset_multi_key", bus4.multi_key, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks    = 0;
    bad_rows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus4.frame_tick) ticks++;
      if (bus4.row_n !== 4'hF) bad_rows++;
    end
    checks++;
    if (ticks != 0 || bad_rows != 0) begin
      failures++;
      $display("FAIL idle: got ticks=%0d bad_rows=%0d required 0 and 0", ticks, bad_rows);
    end
  endtask

  task automatic test_row_seq();
    int bad_row;
    int bad_tick;
    int bad_key;
    int m;
    logic [3:0] one;
    logic [3:0] exp;
    one      = 4'b0001;
    bad_row  = 0;
    bad_tick = 0;
    bad_key  = 0;
    scan_en  = 1'b1;
    for (int i = 0; i < 66; i++) begin
      @(negedge clk);
      m   = i % 33;
      exp = (m == 32) ? 4'hF : ~(one << (m / 8));
      if (bus4.row_n !== exp) begin
        if (bad_row == 0)
          $display("FAIL row_seq: cycle %0d row_n got %h required %h", i, bus4.row_n, exp);
        bad_row++;
      end
      if (bus4.frame_tick !== (m == 32)) bad_tick++;
      if (bus4.key_num !== 16'hFFFF) bad_key++;
    end
    checks++;
    if (bad_row != 0) failures++;
    checks++;
    if (bad_tick != 0) begin
      failures++;
      $display("FAIL tick_period: got %0d misplaced ticks required 0", bad_tick);
    end
    checks++;
    if (bad_key != 0) begin
      failures++;
      $display("FAIL idle_key: got %0d cycles not FFFF required 0", bad_key);
    end
  endtask

  task automatic test_single_key();
    press = 16'h0040;
    wait_ticks(1);
    chk16("single_deb1_first", bus1.key_num, 16'hFFBF);
    wait_ticks(2);
    chk16("single_before4", bus4.key_num, 16'hFFFF);
    wait_ticks(1);
    chk16("single_at4", bus4.key_num, 16'hFFBF);
    @(negedge clk);
    chk1("single_multi", bus4.multi_key, 1'b0);
    press = 16'h0000;
    wait_ticks(3);
    chk16("release_before4", bus4.key_num, 16'hFFBF);
    wait_ticks(1);
    chk16("release_at4", bus4.key_num, 16'hFFFF);
  endtask

  task automatic test_bounce();
    mon_left = 1'b0;
    mon_en   = 1'b1;
    press    = 16'h0001;
    wait_ticks(1);
    chk16("bounce_deb1_f1", bus1.key_num, 16'hFFFE);
    wait_ticks(1);
    chk16("bounce_deb1_f2", bus1.key_num, 16'hFFFE);
    press = 16'h0000;
    wait_ticks(1);
    chk16("bounce_deb1_release", bus1.key_num, 16'hFFFF);
    wait_ticks(4);
    mon_en = 1'b0;
    chk1("bounce_never_left", mon_left, 1'b0);
    chk16("bounce_final", bus4.key_num, 16'hFFFF);
  endtask

  task automatic test_two_keys();
    press = 16'h8001;
    wait_ticks(3);
    chk16("two_before4", bus4.key_num, 16'hFFFF);
    wait_ticks(1);
    chk16("two_at4", bus4.key_num, 16'h7FFE);
    chk1("two_multi_same_cycle", bus4.multi_key, 1'b0);
    @(negedge clk);
    chk1("two_multi_next", bus4.multi_key, 1'b1);
    press = 16'h0000;
    wait_ticks(4);
    chk16("two_release", bus4.key_num, 16'hFFFF);
    chk1("two_multi_lag", bus4.multi_key, 1'b1);
    @(negedge clk);
    chk1("two_multi_clear", bus4.multi_key, 1'b0);
  endtask

  task automatic test_abort();
    int cyc;
    int ticks;
    int bad_rows;
    press = 16'h0040;
    wait_ticks(2);
    chk16("abort_pre", bus4.key_num, 16'hFFFF);
    cyc = 0;
    while (bus4.row_n !== 4'hB && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk16("abort_reach_row2", {12'h000, bus4.row_n}, 16'h000B);
    repeat (3) @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    chk16("abort_row_off", {12'h000, bus4.row_n}, 16'h000F);
    chk16("abort_key_held", bus4.key_num, 16'hFFFF);
    chk1("abort_no_tick", bus4.frame_tick, 1'b0);
    ticks    = 0;
    bad_rows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus4.frame_tick) ticks++;
      if (bus4.row_n !== 4'hF) bad_rows++;
    end
    checks++;
    if (ticks != 0 || bad_rows != 0) begin
      failures++;
      $display("FAIL parked: got ticks=%0d bad_rows=%0d required 0 and 0", ticks, bad_rows);
    end
    scan_en = 1'b1;
    @(negedge clk);
    chk16("restart_row0", {12'h000, bus4.row_n}, 16'h000E);
    repeat (8) @(negedge clk);
    chk16("restart_row1", {12'h000, bus4.row_n}, 16'h000D);
    wait_ticks(1);
    chk16("restart_f3", bus4.key_num, 16'hFFFF);
    wait_ticks(1);
    chk16("restart_f4", bus4.key_num, 16'hFFBF);
  endtask

  task automatic test_reset_mid();
    int cyc;
    cyc = 0;
    while (bus4.row_n !== 4'hD && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk16("midrst_row_n", {12'h000, bus4.row_n}, 16'h000F);
    chk16("midrst_key_num", bus4.key_num, 16'hFFFF);
    chk16("midrst_deb1_key", bus1.key_num, 16'hFFFF);
    chk1("midrst_tick", bus4.frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk16("midrst_restart", {12'h000, bus4.row_n}, 16'h000E);
    press = 16'h0000;
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    scan_en  = 1'b0;
    press    = 16'h0000;
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    mon_left = 1'b0;
    test_reset();
    test_row_seq();
    test_single_key();
    test_bounce();
    test_two_keys();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
